// File: rtl/fetch_stage.sv
// fetch_stage: multi-cycle Y86-64 SEQ fetch unit reading a byte-wide
// instruction memory one byte per request/ack handshake.
// Optional feature: define FETCH_ERR_COUNT_EN to add the err_count output
// (saturating count of fetches that ended in ADR or INS).
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int unsigned IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat,
    output logic        fetch_valid,
    output logic        busy
`ifdef FETCH_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE, HALT} state_t;

    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    state_t      state, state_nx;
    logic [3:0]  idx;       // byte index within the instruction
    logic [3:0]  len;       // decoded length, valid once byte 0 is in
    logic [64:0] addr_ext;  // one extra bit so pc+idx cannot wrap below IMEM_SIZE
    logic        addr_bad;
    logic        take;      // byte accepted this cycle
    logic [3:0]  byte_len;
    logic        byte_ok;
    logic [2:0]  cpos;      // valC byte lane for the current byte

    assign addr_ext    = {1'b0, pc} + {61'd0, idx};
    assign addr_bad    = addr_ext >= 65'(IMEM_SIZE);
    assign fetch_valid = (state == DONE);
    assign busy        = (state == FETCH);
    // jXX/call carry valC in bytes 1..8, the 10-byte forms in bytes 2..9
    assign cpos        = (len == 4'd9) ? idx[2:0] - 3'd1 : idx[2:0] - 3'd2;

    // Decode length and legality of the byte currently on imem_rdata as byte 0
    always_comb begin
        byte_len = 4'd1;
        byte_ok  = 1'b1;
        case (imem_rdata[7:4])
            4'h0, 4'h1, 4'h9:       byte_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: byte_len = 4'd2;
            4'h7, 4'h8:             byte_len = 4'd9;
            4'h3, 4'h4, 4'h5:       byte_len = 4'd10;
            default:                byte_ok  = 1'b0;
        endcase
        case (imem_rdata[7:4])
            4'h2, 4'h7: if (imem_rdata[3:0] > 4'd6) byte_ok = 1'b0;
            4'h6:       if (imem_rdata[3:0] > 4'd3) byte_ok = 1'b0;
            default:    if (imem_rdata[3:0] != 4'd0) byte_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and memory request; request/address held until ack
    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = 64'd0;
        take      = 1'b0;
        case (state)
            IDLE: if (start) state_nx = FETCH;
            FETCH: begin
                if (addr_bad) begin
                    state_nx = DONE;
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = addr_ext[63:0];
                    if (imem_ack) begin
                        take = 1'b1;
                        if (idx == 4'd0) begin
                            if (!byte_ok || byte_len == 4'd1) state_nx = DONE;
                        end else if (idx == len - 4'd1) begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE:    state_nx = (stat == AOK) ? IDLE : HALT;
            default: state_nx = state;
        endcase
    end

    // PC register and instruction field assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            idx   <= 4'd0;
            len   <= 4'd0;
            icode <= 4'd0;
            ifun  <= 4'd0;
            rA    <= 4'hF;
            rB    <= 4'hF;
            valC  <= 64'd0;
            valP  <= 64'd0;
            stat  <= AOK;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (pc_load) pc <= pc_in;
                    idx   <= 4'd0;
                    len   <= 4'd0;
                    icode <= 4'd0;
                    ifun  <= 4'd0;
                    rA    <= 4'hF;
                    rB    <= 4'hF;
                    valC  <= 64'd0;
                    stat  <= AOK;
                end
                FETCH: begin
                    if (addr_bad) begin
                        stat <= ADR;
                        valP <= pc + {60'd0, len};
                    end else if (take) begin
                        if (idx == 4'd0) begin
                            icode <= imem_rdata[7:4];
                            ifun  <= imem_rdata[3:0];
                            if (!byte_ok) begin
                                stat <= INS;
                                valP <= pc + 64'd1;
                            end else begin
                                len <= byte_len;
                                if (byte_len == 4'd1) begin
                                    valP <= pc + 64'd1;
                                    if (imem_rdata[7:4] == 4'h0) stat <= HLT;
                                end else begin
                                    idx <= 4'd1;
                                end
                            end
                        end else begin
                            if (idx == 4'd1 && (len == 4'd2 || len == 4'd10))
                                {rA, rB} <= imem_rdata;
                            if (len == 4'd9 || (len == 4'd10 && idx >= 4'd2))
                                valC[{cpos, 3'b000} +: 8] <= imem_rdata;
                            if (idx == len - 4'd1) valP <= pc + {60'd0, len};
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_ERR_COUNT_EN
    // Saturating count of fetches that reported ADR or INS
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= 16'd0;
        else if (state == DONE && (stat == ADR || stat == INS) && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a byte memory
// responder, directed scenarios and randomized instructions.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] pc_in = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [7:0]  imem_rdata = 8'd0;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
    logic        fetch_valid, busy;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .start(start), .pc_load(pc_load), .pc_in(pc_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat(stat),
        .fetch_valid(fetch_valid), .busy(busy)
    );

    typedef struct {
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic [2:0]  stat;
        int          lat;   // edges from start acceptance to the DONE cycle
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  mem [0:4095];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, start_cyc = 0, cur_wait = 0, waitcnt = 0;
    logic [63:0] model_pc = 64'd0;
    logic [2:0]  last_stat = 3'd1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: instruction = list of bytes starting at p; fields come
    // straight from the Y86-64 encoding rules.
    function automatic exp_t ref_fetch(input logic [63:0] p, input int w);
        exp_t       e;
        logic [7:0] b [10];
        int         got, n, first;
        bit         bad;
        e.icode = 0; e.ifun = 0; e.rA = 4'hF; e.rB = 4'hF;
        e.valC = 0; e.valP = p; e.stat = 3'd1; e.lat = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (p + 64'(i) >= 64'd4096) break;
            b[i] = mem[p[11:0] + 12'(i)];
            got++;
        end
        if (got == 0) begin e.stat = 3'd3; e.lat = 1; return e; end
        e.icode = b[0][7:4];
        e.ifun  = b[0][3:0];
        case (e.icode)
            0, 1, 9:        n = 1;
            2, 6, 10, 11:   n = 2;
            7, 8:           n = 9;
            3, 4, 5:        n = 10;
            default:        n = 0;
        endcase
        if (e.icode == 2 || e.icode == 7) bad = e.ifun > 6;
        else if (e.icode == 6)            bad = e.ifun > 3;
        else                              bad = e.ifun != 0;
        if (n == 0 || bad) begin e.stat = 3'd4; e.lat = w + 1; return e; end
        if ((n == 2 || n == 10) && got >= 2) {e.rA, e.rB} = b[1];
        if (n >= 9) begin
            first = (n == 9) ? 1 : 2;
            for (int i = first; i < n && i < got; i++) e.valC[8*(i-first) +: 8] = b[i];
        end
        if (got < n) begin
            e.stat = 3'd3;
            e.lat  = got * (w + 1) + 1;
        end else begin
            e.stat = (e.icode == 0) ? 3'd2 : 3'd1;
            e.lat  = n * (w + 1);
        end
        e.valP = p + 64'(n);
        return e;
    endfunction

    // Memory responder: acks after cur_wait idle cycles, never beyond IMEM_SIZE
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (rst || !imem_req) begin
            waitcnt = 0;
        end else if (imem_addr >= 64'd4096) begin
            n_tests++; n_fail++;
            $display("FAIL bad_addr: request at %0h, want none at or above 4096", imem_addr);
        end else if (waitcnt >= cur_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr[11:0]];
            waitcnt    = 0;
        end else begin
            waitcnt++;
        end
    end

    // Monitor: every fetch_valid pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && fetch_valid) begin
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_valid: fetch_valid=1 with nothing expected");
            end else begin
                mon_e = q.pop_front();
                check("icode", icode, mon_e.icode);
                check("ifun",  ifun,  mon_e.ifun);
                check("rA",    rA,    mon_e.rA);
                check("rB",    rB,    mon_e.rB);
                check("valC",  valC,  mon_e.valC);
                check("stat",  stat,  mon_e.stat);
                check("latency", 64'(cyc - start_cyc), 64'(mon_e.lat));
                if (mon_e.stat == 3'd1 || mon_e.stat == 3'd2) check("valP", valP, mon_e.valP);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1; start = 1'b0;
        q.delete();
        model_pc = 64'd0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic issue(input logic [63:0] p, input bit load, input int w);
        exp_t e;
        if (load) model_pc = p;
        e = ref_fetch(model_pc, w);
        last_stat = e.stat;
        q.push_back(e);
        cur_wait = w;
        @(negedge clk);
        start = 1'b1; pc_load = load; pc_in = load ? p : {$urandom, $urandom};
        @(posedge clk);
        #1 start_cyc = cyc; start = 1'b0; pc_load = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 400) begin @(negedge clk); k++; end
        if (q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: fetch_valid not seen within 400 cycles, want one pulse");
            do_reset();
        end else begin
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] p;
        logic [3:0]  ic, fn;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        // Reset state, sampled while reset is held and after release
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 64'd0);
        check("rst_stat", stat, 3'd1);
        check("rst_rA", rA, 4'hF);
        check("rst_rB", rB, 4'hF);
        check("rst_icode", icode, 4'd0);
        check("rst_valC", valC, 64'd0);
        check("rst_valP", valP, 64'd0);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", fetch_valid, 1'b0);
        #2 rst = 1'b0;

        // nop at 0, zero-wait
        mem[0] = 8'h10;
        issue(64'd0, 1'b1, 0);
        wait_done();
        check("nop_valP", valP, 64'd1);

        // irmovq $11,%rbx at 16 with two wait cycles per byte
        mem[16] = 8'h30; mem[17] = 8'hF3; mem[18] = 8'h0B;
        for (int i = 19; i < 26; i++) mem[i] = 8'h00;
        issue(64'd16, 1'b1, 2);
        wait_done();
        check("irmovq_valC", valC, 64'd11);
        check("irmovq_rB", rB, 4'd3);
        check("irmovq_valP", valP, 64'd26);

        // Invalid encodings
        mem[200] = 8'hC0;
        issue(64'd200, 1'b1, 1);
        wait_done();
        do_reset();
        mem[210] = 8'h27;
        issue(64'd210, 1'b1, 0);
        wait_done();
        do_reset();

        // jXX running off the end of memory, then HALT ignores start
        mem[4090] = 8'h70;
        issue(64'd4090, 1'b1, 0);
        wait_done();
        @(negedge clk);
        start = 1'b1; pc_load = 1'b1; pc_in = 64'd0;
        @(posedge clk);
        #1 start = 1'b0; pc_load = 1'b0;
        repeat (10) @(negedge clk);
        check("halt_busy", busy, 1'b0);
        check("halt_req", imem_req, 1'b0);
        check("halt_stat", stat, 3'd3);
        check("halt_pc", pc, 64'd4090);
        do_reset();

        // Reset in the middle of a call fetch
        mem[100] = 8'h80;
        issue(64'd100, 1'b1, 3);
        repeat (5) @(negedge clk);
        check("mid_req_before", imem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mid_req", imem_req, 1'b0);
        check("mid_pc", pc, 64'd0);
        check("mid_stat", stat, 3'd1);
        q.delete();
        model_pc = 64'd0;
        @(negedge clk);
        #2 rst = 1'b0;
        issue(64'd100, 1'b1, 0);
        wait_done();
        check("mid_after_pc", pc, 64'd100);

        // Randomized instructions
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 4) == 0) p = 64'($urandom_range(4085, 4100));
            else                           p = 64'($urandom_range(0, 4095));
            ic = 4'($urandom_range(0, 12));
            if (ic == 2 || ic == 7) fn = 4'($urandom_range(0, 6));
            else if (ic == 6)       fn = 4'($urandom_range(0, 3));
            else                    fn = 4'd0;
            if ($urandom_range(0, 6) == 0) fn = 4'($urandom_range(0, 15));
            if (p < 64'd4096) begin
                mem[p[11:0]] = {ic, fn};
                for (int i = 1; i < 10; i++)
                    if (p + 64'(i) < 64'd4096) mem[p[11:0] + 12'(i)] = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) issue(p, 1'b0, $urandom_range(0, 2));
            else                           issue(p, 1'b1, $urandom_range(0, 2));
            wait_done();
            if (last_stat != 3'd1 || $urandom_range(0, 9) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
